wb_stage: RTL and testbench

Write-back stage of the five-stage in-order CPU pipeline, directly upstream of the register file. Accepts one retiring instruction per cycle from the memory stage over a valid/allowin handshake. Holds it in a pipeline register and extracts and extends load data. Drives the register file write port, the decode-stage hazard/bypass port and the debug trace port.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/load_extend.sv | 36 +++
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
// Load-op encodings and the memory-to-write-back payload layout live here.
package wb_pkg;

  localparam int LOAD_OP_W = 3;

  localparam logic [LOAD_OP_W-1:0] LD_W  = 3'd0;
  localparam logic [LOAD_OP_W-1:0] LD_B  = 3'd1;
  localparam logic [LOAD_OP_W-1:0] LD_BU = 3'd2;
  localparam logic [LOAD_OP_W-1:0] LD_H  = 3'd3;
  localparam logic [LOAD_OP_W-1:0] LD_HU = 3'd4;

  typedef struct packed {
    logic [31:0]          pc;
    logic                 rf_we;
    logic [4:0]           dest;
    logic [31:0]          result;
    logic                 res_from_mem;
    logic [LOAD_OP_W-1:0] load_op;
    logic [31:0]          mem_rdata;
  } ms_ws_t;

  localparam int MS_WS_W = $bits(ms_ws_t);

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a loaded word and sign/zero extends it.
// Purely combinational; misaligned halves simply ignore addr[0].
module load_extend
  import wb_pkg::*;
(
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr,
  input  logic [31:0]          rdata,
  output logic [31:0]          ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Undefined encodings fall through to a full-word load.
  always_comb begin
    case (load_op)
      LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext_data = {24'd0, byte_sel};
      LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ext_data = {16'd0, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry pipeline register feeding the register file, bypass and trace ports; write visible the cycle after accept.
// ws_stall holds the entry (allowin drops only when occupied and stalled); DIFFTEST_EN adds commit_valid/commit_pc/commit_cnt.
module wb_stage
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic                 ms_rf_we,
  input  logic [4:0]           ms_dest,
  input  logic [31:0]          ms_result,
  input  logic                 ms_res_from_mem,
  input  logic [LOAD_OP_W-1:0] ms_load_op,
  input  logic [31:0]          ms_mem_rdata,
  input  logic                 ws_stall,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [4:0]           ws_fwd_dest,
  output logic [31:0]          ws_fwd_data,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`ifdef DIFFTEST_EN
  ,
  output logic                 commit_valid,
  output logic [31:0]          commit_pc,
  output logic [63:0]          commit_cnt
`endif
);

  logic        ws_valid;
  ms_ws_t      ws_pl;
  logic        ws_ready_go;
  logic        commit;
  logic [31:0] load_data;
  logic [31:0] final_data;

  assign ws_ready_go = !ws_stall;
  assign ws_allowin  = !ws_valid || ws_ready_go;
  assign commit      = ws_valid && ws_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid <= 1'b0;
      ws_pl    <= '0;
    end else begin
      if (ws_allowin) begin
        ws_valid <= ms_to_ws_valid;
      end
      if (ms_to_ws_valid && ws_allowin) begin
        ws_pl <= '{pc:           ms_pc,
                   rf_we:        ms_rf_we,
                   dest:         ms_dest,
                   result:       ms_result,
                   res_from_mem: ms_res_from_mem,
                   load_op:      ms_load_op,
                   mem_rdata:    ms_mem_rdata};
      end
    end
  end

  load_extend u_load_extend (
    .load_op  (ws_pl.load_op),
    .addr     (ws_pl.result[1:0]),
    .rdata    (ws_pl.mem_rdata),
    .ext_data (load_data)
  );

  assign final_data = ws_pl.res_from_mem ? load_data : ws_pl.result;

  // r0 is hard-wired zero, so a dest of 0 never writes or traces.
  assign rf_we    = commit && ws_pl.rf_we && (ws_pl.dest != 5'd0);
  assign rf_waddr = ws_pl.dest;
  assign rf_wdata = final_data;

  // Held while stalled so decode keeps seeing the pending write.
  assign ws_fwd_dest = (ws_valid && ws_pl.rf_we) ? ws_pl.dest : 5'd0;
  assign ws_fwd_data = final_data;

  assign debug_wb_pc       = commit ? ws_pl.pc : 32'd0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

`ifdef DIFFTEST_EN
  assign commit_valid = commit;
  assign commit_pc    = commit ? ws_pl.pc : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_cnt <= 64'd0;
    end else if (commit) begin
      commit_cnt <= commit_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load/stall/reset scenarios plus a randomized run against a behavioural model.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_res_from_mem;
  logic [2:0]  ms_load_op;
  logic [31:0] ms_mem_rdata;
  logic        ws_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`ifdef DIFFTEST_EN
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [63:0] commit_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result),
    .ms_res_from_mem   (ms_res_from_mem),
    .ms_load_op        (ms_load_op),
    .ms_mem_rdata      (ms_mem_rdata),
    .ws_stall          (ws_stall),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`ifdef DIFFTEST_EN
    ,
    .commit_valid      (commit_valid),
    .commit_pc         (commit_pc),
    .commit_cnt        (commit_cnt)
`endif
  );

  // Reference load semantics written as plain shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input int op, input int addr, input logic [31:0] rd);
    logic [31:0] v;
    if (op == 1 || op == 2) begin
      v = (rd >> (8 * addr)) & 32'hFF;
      if (op == 1 && v >= 32'd128) v = v - 32'd256;
    end else if (op == 3 || op == 4) begin
      v = (rd >> (16 * (addr / 2))) & 32'hFFFF;
      if (op == 3 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic idle();
    ms_to_ws_valid  = 1'b0;
    ms_pc           = 32'd0;
    ms_rf_we        = 1'b0;
    ms_dest         = 5'd0;
    ms_result       = 32'd0;
    ms_res_from_mem = 1'b0;
    ms_load_op      = 3'd0;
    ms_mem_rdata    = 32'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic rfm, input logic [2:0] op,
                       input logic [31:0] rd);
    ms_to_ws_valid  = 1'b1;
    ms_pc           = pc;
    ms_rf_we        = we;
    ms_dest         = dest;
    ms_result       = res;
    ms_res_from_mem = rfm;
    ms_load_op      = op;
    ms_mem_rdata    = rd;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ws_stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ws_allowin !== 1'b1 || rf_we !== 1'b0 || ws_fwd_dest !== 5'd0) begin
      fails++;
      $display("FAIL reset_ctrl: allowin=%b rf_we=%b fwd_dest=%0d, want 1 0 0", ws_allowin, rf_we, ws_fwd_dest);
    end
    tests++;
    if (debug_wb_pc !== 32'd0 || debug_wb_rf_we !== 4'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_debug: pc=%h we=%h wnum=%0d wdata=%h, want all 0", debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
`ifdef DIFFTEST_EN
    tests++;
    if (commit_cnt !== 64'd0 || commit_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_difftest: cnt=%0d valid=%b, want 0 0", commit_cnt, commit_valid);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  ops  [5] = '{LD_B, LD_BU, LD_H, LD_HU, LD_W};
    logic [31:0] addrs[5] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd2};
    logic [31:0] rds  [5] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
    for (int i = 0; i < 25; i++) begin
      logic [2:0]  op;
      logic [31:0] ad, rd, ex;
      if (i < 5) begin
        op = ops[i]; ad = addrs[i]; rd = rds[i]; ex = exps[i];
      end else begin
        op = 3'($urandom_range(0, 7));
        ad = $urandom;
        rd = $urandom;
        ex = ref_load(int'(op), int'(ad % 4), rd);
      end
      @(posedge clk); #1;
      drive(32'h2000 + 32'(i * 4), 1'b1, 5'd5, ad, 1'b1, op, rd);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      tests++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== ex || debug_wb_rf_we !== 4'hF) begin
        fails++;
        $display("FAIL load_%0d op=%0d addr=%0d rd=%h: we=%b waddr=%0d wdata=%h, want 1 5 %h", i, op, ad[1:0], rd, rf_we, rf_waddr, rf_wdata, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      if (i <= 10) drive(32'h1000 + 32'(i * 4), 1'b1, 5'(i), 32'(i * 17), 1'b0, LD_W, 32'd0);
      else idle();
      @(negedge clk);
      tests++;
      if (ws_allowin !== 1'b1) begin
        fails++;
        $display("FAIL b2b_allowin_%0d: allowin=%b, want 1", i, ws_allowin);
      end
      if (i > 1) begin
        if (rf_we === 1'b1) pulses++;
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'(i - 1) || rf_wdata !== 32'((i - 1) * 17) || debug_wb_pc !== 32'h1000 + 32'((i - 1) * 4)) begin
          fails++;
          $display("FAIL b2b_write_%0d: we=%b waddr=%0d wdata=%0d pc=%h, want 1 %0d %0d", i, rf_we, rf_waddr, rf_wdata, debug_wb_pc, i - 1, (i - 1) * 17);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0 || pulses != 10) begin
      fails++;
      $display("FAIL b2b_count: pulses=%0d trailing_we=%b, want 10 0", pulses, rf_we);
    end
  endtask

  task automatic test_stall();
    int writes = 0;
    @(posedge clk); #1;
    drive(32'h3000, 1'b1, 5'd7, 32'h77, 1'b0, LD_W, 32'd0);
    @(posedge clk); #1;
    // A second offer while stalled must be refused and later accepted.
    drive(32'h3004, 1'b1, 5'd8, 32'h88, 1'b0, LD_W, 32'd0);
    ws_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (ws_allowin !== 1'b0 || rf_we !== 1'b0 || ws_fwd_dest !== 5'd7 || ws_fwd_data !== 32'h77) begin
        fails++;
        $display("FAIL stall_hold_%0d: allowin=%b we=%b fwd=%0d/%h, want 0 0 7/77", k, ws_allowin, rf_we, ws_fwd_dest, ws_fwd_data);
      end
      @(posedge clk); #1;
    end
    ws_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rf_we === 1'b1 && rf_waddr === 5'd7) writes++;
      if (k == 1) begin
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin
          fails++;
          $display("FAIL stall_next: we=%b waddr=%0d wdata=%h, want 1 8 88", rf_we, rf_waddr, rf_wdata);
        end
      end
      @(posedge clk); #1;
      idle();
    end
    tests++;
    if (writes != 1) begin
      fails++;
      $display("FAIL stall_once: writes to r7=%0d, want 1", writes);
    end
    // Stall with an empty stage must not block acceptance.
    ws_stall = 1'b1;
    drive(32'h3100, 1'b1, 5'd9, 32'h99, 1'b0, LD_W, 32'd0);
    @(negedge clk);
    tests++;
    if (ws_allowin !== 1'b1) begin
      fails++;
      $display("FAIL stall_empty: allowin=%b, want 1", ws_allowin);
    end
    @(posedge clk); #1;
    idle();
    ws_stall = 1'b0;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      fails++;
      $display("FAIL stall_empty_write: we=%b waddr=%0d, want 1 9", rf_we, rf_waddr);
    end
  endtask

  task automatic test_dest0();
    @(posedge clk); #1;
    drive(32'h4000, 1'b1, 5'd0, 32'h1234, 1'b0, LD_W, 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'd0 || ws_fwd_dest !== 5'd0) begin
      fails++;
      $display("FAIL dest0: we=%b dbg_we=%h fwd=%0d, want 0 0 0", rf_we, debug_wb_rf_we, ws_fwd_dest);
    end
  endtask

  task automatic test_reset_mid_stall();
    int writes = 0;
    @(posedge clk); #1;
    drive(32'h5000, 1'b1, 5'd12, 32'hABCD, 1'b0, LD_W, 32'd0);
    @(posedge clk); #1;
    idle();
    ws_stall = 1'b1;
    @(negedge clk);
    tests++;
    if (ws_fwd_dest !== 5'd12) begin
      fails++;
      $display("FAIL rst_stall_pre: fwd=%0d, want 12", ws_fwd_dest);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (rf_we !== 1'b0 || ws_fwd_dest !== 5'd0 || ws_allowin !== 1'b1 || debug_wb_pc !== 32'd0 || debug_wb_rf_wdata !== 32'd0) begin
      fails++;
      $display("FAIL rst_stall_now: we=%b fwd=%0d allowin=%b pc=%h wdata=%h, want 0 0 1 0 0", rf_we, ws_fwd_dest, ws_allowin, debug_wb_pc, debug_wb_rf_wdata);
    end
`ifdef DIFFTEST_EN
    tests++;
    if (commit_cnt !== 64'd0) begin
      fails++;
      $display("FAIL rst_stall_cnt: cnt=%0d, want 0", commit_cnt);
    end
`endif
    @(posedge clk); #1;
    reset    = 1'b0;
    ws_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rf_we === 1'b1) writes++;
      @(posedge clk); #1;
    end
    tests++;
    if (writes != 0) begin
      fails++;
      $display("FAIL rst_stall_post: writes=%0d, want 0", writes);
    end
  endtask

  // Model: at most one instruction is resident; it retires in any cycle without stall.
  task automatic test_random();
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 0, m_val = 0;
    logic        m_we = 0;
    logic [4:0]  m_dest = 0;
    int          commits = 0;
    int          bad = 0;
    logic        in_v, st;
    for (int c = 0; c < 400; c++) begin
      logic        exp_commit, exp_we;
      logic [4:0]  exp_fwd;
      logic [31:0] exp_pc;
      in_v = ($urandom_range(0, 3) != 0);
      st   = ($urandom_range(0, 3) == 0);
      drive($urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom);
      ms_to_ws_valid = in_v;
      ws_stall = st;
      @(negedge clk);
      exp_commit = m_valid && !st;
      exp_we     = exp_commit && m_we && (m_dest != 0);
      exp_fwd    = (m_valid && m_we) ? m_dest : 5'd0;
      exp_pc     = exp_commit ? m_pc : 32'd0;
      tests++;
      if (rf_we !== exp_we || ws_allowin !== !(m_valid && st) || ws_fwd_dest !== exp_fwd || debug_wb_pc !== exp_pc ||
          (m_valid && ws_fwd_data !== m_val) || (exp_we && (rf_waddr !== m_dest || rf_wdata !== m_val))) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand_%0d: we=%b allow=%b fwd=%0d pc=%h wd=%h, want we=%b allow=%b fwd=%0d pc=%h wd=%h",
                   c, rf_we, ws_allowin, ws_fwd_dest, debug_wb_pc, rf_wdata, exp_we, !(m_valid && st), exp_fwd, exp_pc, m_val);
      end
      if (exp_commit) commits++;
      if (!m_valid || !st) begin
        m_valid = in_v;
        if (in_v) begin
          m_pc   = ms_pc;
          m_we   = ms_rf_we;
          m_dest = ms_dest;
          m_val  = ms_res_from_mem ? ref_load(int'(ms_load_op), int'(ms_result % 4), ms_mem_rdata) : ms_result;
        end
      end
      @(posedge clk); #1;
    end
`ifdef DIFFTEST_EN
    tests++;
    if (commit_cnt !== 64'(commits) + 64'd9) begin
      fails++;
      $display("FAIL rand_commit_cnt: cnt=%0d, want %0d", commit_cnt, commits + 9);
    end
`endif
    idle();
    ws_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_back_to_back();
    test_stall();
    test_dest0();
    test_reset_mid_stall();
`ifdef DIFFTEST_EN
    // Pre-charge the counter with a known number of commits before the random run.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(32'h6000, 1'b0, 5'd0, 32'd0, 1'b0, LD_W, 32'd0);
    end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
